// File: rtl/hmove_sequencer.sv
// HMOVE motion-clock sequencer: 15 motion ticks, one every 4 color clocks, with a pulse budget per object.
// Optional HMOVE blank extension is compiled in with `define HMOVE_BLANK_EN.
module hmove_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       hmove,
  input  logic [3:0] hm_p0,
  input  logic [3:0] hm_p1,
  input  logic [3:0] hm_m0,
  input  logic [3:0] hm_m1,
  input  logic [3:0] hm_bl,
  input  logic       hblank,
  input  logic       line_start,
  output logic [4:0] mclk,
  output logic       busy,
  output logic       ext_blank
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [5:0] LAST_IDX = 6'd57;

  logic [1:0] state;
  logic [5:0] idx;
  logic [4:0] active;
  logic [4:0] keep;
  logic [3:0] k;
  logic       tick;
  logic [3:0] n [5];

  always_comb begin
    n[0] = {~hm_p0[3], hm_p0[2:0]};
    n[1] = {~hm_p1[3], hm_p1[2:0]};
    n[2] = {~hm_m0[3], hm_m0[2:0]};
    n[3] = {~hm_m1[3], hm_m1[2:0]};
    n[4] = {~hm_bl[3], hm_bl[2:0]};
  end

  // In ST_RUN idx is the ce index of the current ce; ticks fall on idx = 1 + 4k.
  assign k    = idx[5:2];
  assign tick = (state == ST_RUN) && ce && (idx[1:0] == 2'd1) && !hmove && !reset;

  always_comb begin
    keep = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      keep[i] = active[i] && (k < n[i]);
    end
  end

  assign mclk = tick ? keep : '0;
  assign busy = (state != ST_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      active <= '0;
    end else if (hmove) begin
      state  <= ST_ARM;
      idx    <= '0;
      active <= '1;
    end else if (ce) begin
      case (state)
        ST_ARM: begin
          state <= ST_RUN;
          idx   <= 6'd1;
        end
        ST_RUN: begin
          // Flags only ever drop: keep excludes already-cleared objects.
          if (idx[1:0] == 2'd1) active <= keep;
          if (idx == LAST_IDX) state <= ST_IDLE;
          idx <= idx + 6'd1;
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HMOVE_BLANK_EN
  logic       blank_latch;
  logic [3:0] low_ce;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_latch <= 1'b0;
      low_ce      <= '0;
    end else begin
      if (hmove) blank_latch <= 1'b1;
      else if (line_start) blank_latch <= 1'b0;
      // Counts ce since hblank fell, saturating once the extension has expired.
      if (hblank) low_ce <= '0;
      else if (ce && (low_ce != 4'd8)) low_ce <= low_ce + 4'd1;
    end
  end

  assign ext_blank = hblank || (blank_latch && (low_ce < 4'd8) && !reset);
`else
  logic unused_line_start;
  assign unused_line_start = line_start;
  assign ext_blank = hblank;
`endif

endmodule
